// File: rtl/boot_pkg.sv
// -----------------------------------------------------------------------------
// boot_pkg
// Shared definitions for the UART boot loader:
//   - boot_state_t : packet framing states (SYNC, LEN, DATA, CSUM, DONE, ERR)
//   - SYNC_BYTE_DEFAULT : default packet start marker
//   - csum_add()   : running 8-bit additive checksum step
// -----------------------------------------------------------------------------
package boot_pkg;

    typedef enum logic [2:0] {
        SYNC = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } boot_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Checksum is the plain byte sum, truncated to 8 bits.
    function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] data);
        return sum + data;
    endfunction

endpackage

// File: rtl/boot_timeout_cnt.sv
// -----------------------------------------------------------------------------
// boot_timeout_cnt
// Inter-byte watchdog for the boot loader. Down-counter that is reloaded with
// TIMEOUT-1 whenever clr is high and decrements while run is high.
// Ports:
//   Clk     in  system clock
//   Rst     in  synchronous active-high reset
//   clr     in  reload the counter (a byte arrived, or the watchdog is idle)
//   run     in  count this cycle (a packet is in progress)
//   expired out counter has reached zero while running
// -----------------------------------------------------------------------------
module boot_timeout_cnt #(
    parameter int TIMEOUT = 50000
) (
    input  logic Clk,
    input  logic Rst,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    // Reload has priority over counting so that a byte arriving on the
    // expiry cycle restarts the window. The count parks at zero once reached.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= CW'(TIMEOUT - 1);
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign expired = run && (cnt == '0);

endmodule

// File: rtl/uart_boot_ctrl.sv
// -----------------------------------------------------------------------------
// uart_boot_ctrl
// Power-up boot loader. Frames received UART bytes as
//   SYNC, LEN, LEN data bytes, CSUM
// writes the data bytes into memory from BASE_ADDR upward and releases the
// CPU once a packet with a good checksum has been accepted.
// Ports:
//   Clk, Rst                  clock, synchronous active-high reset
//   rx_valid/rx_data/rx_fe    received byte strobe, byte, frame error
//   mem_we/mem_addr/mem_wdata memory write port (one-cycle strobe per byte)
//   cpu_hold                  1 keeps the CPU in reset
//   boot_done                 packet accepted, checksum good (terminal)
//   boot_err                  last packet aborted
//   bytes_loaded              data bytes written in current/last packet
// -----------------------------------------------------------------------------
module uart_boot_ctrl
    import boot_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [7:0]        SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter int                TIMEOUT   = 50000
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_fe,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              boot_done,
    output logic              boot_err,
    output logic [7:0]        bytes_loaded
);

    boot_state_t       state, next_state;
    logic [7:0]        remaining;
    logic [7:0]        sum;
    logic [ADDR_W-1:0] addr;

    logic running;
    logic expired;
    logic start_pkt;
    logic len_ok;
    logic do_write;
    logic pkt_ok;
    logic abort;

    assign running = (state == LEN) || (state == DATA) || (state == CSUM);

    boot_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .Clk     (Clk),
        .Rst     (Rst),
        .clr     (rx_valid || !running),
        .run     (running),
        .expired (expired)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= SYNC;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode. ERR is never resident: an abort flags boot_err and
    // drops straight back to SYNC on the same edge. A byte arriving on the
    // timeout cycle is handled as a byte, so rx_valid is tested first.
    always_comb begin
        next_state = state;
        start_pkt  = 1'b0;
        len_ok     = 1'b0;
        do_write   = 1'b0;
        pkt_ok     = 1'b0;
        abort      = 1'b0;

        case (state)
            SYNC: begin
                if (rx_valid && !rx_fe && (rx_data == SYNC_BYTE)) begin
                    start_pkt  = 1'b1;
                    next_state = LEN;
                end
            end
            LEN: begin
                if (rx_valid) begin
                    if (rx_fe || (rx_data == 8'h00)) begin
                        abort = 1'b1;
                    end else begin
                        len_ok     = 1'b1;
                        next_state = DATA;
                    end
                end else if (expired) begin
                    abort = 1'b1;
                end
            end
            DATA: begin
                if (rx_valid) begin
                    if (rx_fe) begin
                        abort = 1'b1;
                    end else begin
                        do_write = 1'b1;
                        if (remaining == 8'd1) begin
                            next_state = CSUM;
                        end
                    end
                end else if (expired) begin
                    abort = 1'b1;
                end
            end
            CSUM: begin
                if (rx_valid) begin
                    if (rx_fe || (rx_data != sum)) begin
                        abort = 1'b1;
                    end else begin
                        pkt_ok     = 1'b1;
                        next_state = DONE;
                    end
                end else if (expired) begin
                    abort = 1'b1;
                end
            end
            DONE: begin
                next_state = DONE;
            end
            default: begin
                next_state = SYNC;
            end
        endcase

        if (abort) begin
            next_state = SYNC;
        end
    end

    // Datapath and registered outputs. mem_we is a one-cycle pulse that
    // follows the accepted data byte; mem_addr/mem_wdata hold their last
    // value between writes. Reset wins over a byte on the same edge, so a
    // reset mid-packet never produces a partial write.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            mem_we       <= 1'b0;
            mem_addr     <= BASE_ADDR;
            mem_wdata    <= 8'h00;
            cpu_hold     <= 1'b1;
            boot_done    <= 1'b0;
            boot_err     <= 1'b0;
            bytes_loaded <= 8'h00;
            remaining    <= 8'h00;
            sum          <= 8'h00;
            addr         <= BASE_ADDR;
        end else begin
            mem_we <= do_write;

            if (start_pkt) begin
                boot_err     <= 1'b0;
                bytes_loaded <= 8'h00;
            end

            if (len_ok) begin
                remaining <= rx_data;
                sum       <= 8'h00;
                addr      <= BASE_ADDR;
            end

            if (do_write) begin
                mem_addr     <= addr;
                mem_wdata    <= rx_data;
                addr         <= addr + ADDR_W'(1);
                sum          <= csum_add(sum, rx_data);
                bytes_loaded <= bytes_loaded + 8'd1;
                remaining    <= remaining - 8'd1;
            end

            if (pkt_ok) begin
                boot_done <= 1'b1;
                cpu_hold  <= 1'b0;
            end

            if (abort) begin
                boot_err <= 1'b1;
            end
        end
    end

endmodule
